oversample_framer: RTL and testbench

Upstream feeder for the oversampled-bit sorter: synchronizes an asynchronous serial line, samples it on an OSF-rate strobe, and packs SAMPLES*OSF consecutive samples into one parallel frame. Each completed frame is presented on a valid/ready handshake whose data port connects directly to the sorter's DataIn. Frame start is triggered by a line falling edge, optionally free-running (see Configuration).

---
 rtl/framer_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/oversample_framer.sv | 142 ++++++++++++++
 tb/tb_oversample_framer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared types and constants for the oversampled-line framer.
package framer_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; q_o follows d_i after 2 cycles.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/oversample_framer.sv
// Packs SAMPLES*OSF strobed line samples into a frame on a valid/ready output; frame valid the cycle after the last strobe.
// FRAMER_EDGE_START_EN: start on a line falling edge; otherwise capture free-runs. A frame that cannot be held is dropped and flags overrun.
module oversample_framer
  import framer_pkg::*;
#(
  parameter int unsigned SAMPLES = 2,
  parameter int unsigned OSF     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rx_in_i,
  input  logic                     sample_en_i,
  input  logic                     frame_ready_i,
  output logic [SAMPLES*OSF-1:0]   data_out_o,
  output logic                     frame_valid_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int unsigned N  = SAMPLES * OSF;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic          rx_s;
  logic          start;
  logic          frame_done;
  logic [N-1:0]  frame_dat;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  data_q, data_d;
  logic          vld_q, vld_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;

  sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_in_i),
    .q_o    (rx_s)
  );

`ifdef FRAMER_EDGE_START_EN
  localparam state_e ST_HOME = IDLE;
  logic rx_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_prev_q <= LINE_IDLE;
    end else if (sample_en_i) begin
      rx_prev_q <= rx_s;
    end
  end

  assign start  = rx_prev_q & ~rx_s;
  assign busy_d = (state_d == CAPTURE);
`else
  localparam state_e ST_HOME = CAPTURE;
  assign start  = 1'b0;
  assign busy_d = 1'b1;
`endif

  // The sample taken this strobe lands in the LSB, so the first sample ends at the MSB.
  assign frame_dat = {shift_q[N-2:0], rx_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    if (sample_en_i) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_d = frame_dat;
            cnt_d   = CW'(1);
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          shift_d = frame_dat;
          if (cnt_q == LAST_CNT) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = ST_HOME;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_HOME;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A new frame may reuse the output register only if the held one is gone or leaving now.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (vld_q && frame_ready_i) begin
      vld_d = 1'b0;
    end
    if (frame_done) begin
      if (!vld_q || frame_ready_i) begin
        data_d = frame_dat;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HOME;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out_o    = data_q;
  assign frame_valid_o = vld_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_oversample_framer.sv
// Scoreboard bench for oversample_framer (SAMPLES=2, OSF=8): directed frames, overrun, accept-on-complete, reset abort.
module tb_oversample_framer;

  localparam int N = 16;
`ifdef FRAMER_EDGE_START_EN
  localparam logic FREE_RUN = 1'b0;
`else
  localparam logic FREE_RUN = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          se;
  logic          rdy;
  logic [N-1:0]  dout;
  logic          vld;
  logic          busy;
  logic          ovr;

  int            checks = 0;
  int            errors = 0;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  exp_dat;

  always #5 clk = ~clk;

  oversample_framer #(.SAMPLES(2), .OSF(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rx_in_i       (rx),
    .sample_en_i   (se),
    .frame_ready_i (rdy),
    .data_out_o    (dout),
    .frame_valid_o (vld),
    .busy_o        (busy),
    .overrun_o     (ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are judged on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Line settles 3 cycles ahead of the strobe so the synchronizer has caught up.
  task automatic send_bit(input logic b, input logic rdy_pulse);
    rx = b;
    se = 1'b0;
    repeat (3) tick();
    se = 1'b1;
    if (rdy_pulse) rdy = 1'b1;
    tick();
    se = 1'b0;
    if (rdy_pulse) rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] f, input int nbits, input logic pulse_last);
    for (int i = N - 1; i >= N - nbits; i--) begin
      send_bit(f[i], pulse_last && (i == 0));
    end
  endtask

  task automatic prime();
`ifdef FRAMER_EDGE_START_EN
    send_bit(1'b1, 1'b0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    se    = 1'b0;
    rdy   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    prime();
  endtask

  always @(negedge clk) begin
    if (rst_n && vld && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %h, expected no frame", dout);
      end else begin
        exp_dat = exp_q.pop_front();
        chk("frame_data", dout, exp_dat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    se    = 1'b0;
    rdy   = 1'b0;
    repeat (2) tick();
    chk("reset_data", dout, 0);
    chk("reset_vld", vld, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ovr", ovr, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("busy_after_reset", busy, FREE_RUN);
    prime();

    // Basic frame, immediately accepted, then a second different pattern.
    rdy = 1'b1;
    exp_q.push_back(16'h00FF);
    send_frame(16'h00FF, N, 1'b0);
    chk("a_vld", vld, 1);
    chk("a_data", dout, 16'h00FF);
    tick();
    chk("a_vld_drop", vld, 0);
    exp_q.push_back(16'h3A5B);
    send_frame(16'h3A5B, N, 1'b0);
    tick();

    // Overrun: second frame arrives while the first is still held.
    do_reset();
    exp_q.push_back(16'h1235);
    send_frame(16'h1235, N, 1'b0);
    chk("c_vld1", vld, 1);
    chk("c_data1", dout, 16'h1235);
    chk("c_ovr1", ovr, 0);
    send_frame(16'h4EEF, N, 1'b0);
    chk("c_vld2", vld, 1);
    chk("c_data2", dout, 16'h1235);
    chk("c_ovr2", ovr, 1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("c_vld_drop", vld, 0);
    chk("c_ovr_sticky", ovr, 1);

    // Accept lands in the same cycle the next frame completes: no bubble, no overrun.
    do_reset();
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'h700F);
    send_frame(16'h0F0F, N, 1'b0);
    send_frame(16'h700F, N, 1'b1);
    chk("d_vld", vld, 1);
    chk("d_data", dout, 16'h700F);
    chk("d_ovr", ovr, 0);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("d_vld_drop", vld, 0);

    // Reset in the middle of a capture with a frame pending.
    do_reset();
    send_frame(16'h00FF, N, 1'b0);
    send_frame(16'h0123, 10, 1'b0);
    chk("e_busy_pre", busy, 1);
    chk("e_vld_pre", vld, 1);
    rst_n = 1'b0;
    #1;
    chk("e_busy_rst", busy, 0);
    chk("e_vld_rst", vld, 0);
    chk("e_data_rst", dout, 0);
    do_reset();
    rdy = 1'b1;
    exp_q.push_back(16'h3C5B);
    send_frame(16'h3C5B, N, 1'b0);
    tick();

`ifdef FRAMER_EDGE_START_EN
    // Idle-high line never starts a capture.
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send_bit(1'b1, 1'b0);
    end
    chk("f_busy", busy, 0);
    chk("f_vld", vld, 0);
`else
    // Strobe every cycle on a constant-high line: one all-ones frame per 16 cycles.
    do_reset();
    rdy = 1'b1;
    rx  = 1'b1;
    repeat (4) exp_q.push_back(16'hFFFF);
    se = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      chk("f_vld_cycle", vld, (i % 16) == 15);
    end
    se = 1'b0;
    chk("f_busy", busy, 1);
    tick();
`endif

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
